// File: rtl/beat_timing_pkg.sv
// Shared types for the beat/phase timing generator: sequencer states, beat codes
// and the beat-to-W level decode.
package beat_timing_pkg;

  typedef enum logic [2:0] {HALT, PH1, PH2, PH3, GAP} state_e;

  typedef enum logic [1:0] {W0, W1B, W2B, W3B} beat_e;

  // Returns {W3, W2, W1}; W0 is the all-low pre-beat.
  function automatic logic [2:0] beat_to_w(input beat_e beat);
    logic [2:0] w;
    case (beat)
      W1B:     w = 3'b001;
      W2B:     w = 3'b010;
      W3B:     w = 3'b100;
      default: w = 3'b000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/qd_sync_edge.sv
// Two-flop synchronizer for the asynchronous start key with a registered
// rising-edge pulse; everything clears to 0 while rst_ni is low.
module qd_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/beat_timing_gen.sv
// Beat (W1..W3) and phase (T1..T3) timing generator for the hardwired controller.
// Define BEAT_SINGLE_STEP_EN to add the DP single-step input.
module beat_timing_gen
  import beat_timing_pkg::*;
#(
  parameter int PHASE_LEN = 1,
  parameter int GAP_LEN   = 1
) (
  input  logic MF,
  input  logic CLR,
  input  logic QD,
  input  logic SHORT,
  input  logic LONG,
  input  logic STOP,
`ifdef BEAT_SINGLE_STEP_EN
  input  logic DP,
`endif
  output logic W1,
  output logic W2,
  output logic W3,
  output logic T1,
  output logic T2,
  output logic T3,
  output logic RUN
);

  localparam int MAX_LEN = (PHASE_LEN > GAP_LEN) ? PHASE_LEN : GAP_LEN;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CW-1:0] PH_LAST  = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  state_e        state_q, state_d;
  beat_e         beat_q, beat_d, beat_next;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    w_q, w_d;
  logic [2:0]    t_q, t_d;
  logic          run_q, run_d;
  logic          short_q, short_d, long_q, long_d, stop_q, stop_d;
  logic          qd_rise;
  logic          halt_req;

  qd_sync_edge u_qd_sync (
    .clk_i  (MF),
    .rst_ni (CLR),
    .d_i    (QD),
    .rise_o (qd_rise)
  );

`ifdef BEAT_SINGLE_STEP_EN
  assign halt_req = stop_q | DP;
`else
  assign halt_req = stop_q;
`endif

  // Successor beat from the controller responses captured as T3 fell.
  always_comb begin
    beat_next = W1B;
    case (beat_q)
      W1B:     beat_next = short_q ? W1B : W2B;
      W2B:     beat_next = long_q ? W3B : W1B;
      default: beat_next = W1B;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    t_d     = t_q;
    run_d   = run_q;
    short_d = short_q;
    long_d  = long_q;
    stop_d  = stop_q;
    cnt_inc = cnt_q + CW'(1);
    case (state_q)
      HALT: begin
        if (qd_rise) begin
          state_d = PH1;
          cnt_d   = '0;
          t_d     = 3'b001;
          run_d   = 1'b1;
        end
      end
      PH1: begin
        if (cnt_q == PH_LAST) begin
          state_d = PH2;
          cnt_d   = '0;
          t_d     = 3'b010;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PH2: begin
        if (cnt_q == PH_LAST) begin
          state_d = PH3;
          cnt_d   = '0;
          t_d     = 3'b100;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PH3: begin
        if (cnt_q == PH_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
          t_d     = 3'b000;
          short_d = SHORT;
          long_d  = LONG;
          stop_d  = STOP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          beat_d = beat_next;
          w_d    = beat_to_w(beat_next);
          cnt_d  = '0;
          if (halt_req) begin
            state_d = HALT;
            run_d   = 1'b0;
          end else begin
            state_d = PH1;
            t_d     = 3'b001;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = HALT;
        cnt_d   = '0;
        t_d     = 3'b000;
        run_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MF or negedge CLR) begin
    if (!CLR) begin
      state_q <= HALT;
      beat_q  <= W0;
      cnt_q   <= '0;
      w_q     <= 3'b000;
      t_q     <= 3'b000;
      run_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      t_q     <= t_d;
      run_q   <= run_d;
      short_q <= short_d;
      long_q  <= long_d;
      stop_q  <= stop_d;
    end
  end

  assign {W3, W2, W1} = w_q;
  assign {T3, T2, T1} = t_q;
  assign RUN          = run_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Scoreboard bench for beat_timing_gen: two instances (1/1 and 3/2 timing) driven
// one at a time from planned beat sequences with random noise on the inputs.
module tb_beat_timing_gen;

  localparam int P0 = 1;
  localparam int G0 = 1;
  localparam int P1 = 3;
  localparam int G1 = 2;

  typedef struct {
    int         dut;
    int         start;
    logic [2:0] w;
    bit         halt;
    logic [2:0] next_w;
  } rec_t;

  logic       MF = 1'b0;
  logic       CLR = 1'b0;
  logic [1:0] qd = 2'b00;
  logic       short_s = 1'b0;
  logic       long_s = 1'b0;
  logic       stop_s = 1'b0;
`ifdef BEAT_SINGLE_STEP_EN
  logic       dp = 1'b0;
`endif
  logic w1_0, w2_0, w3_0, t1_0, t2_0, t3_0, run_0;
  logic w1_1, w2_1, w3_1, t1_1, t2_1, t3_1, run_1;
  logic [6:0] obs [2];

  assign obs[0] = {w3_0, w2_0, w1_0, t3_0, t2_0, t1_0, run_0};
  assign obs[1] = {w3_1, w2_1, w1_1, t3_1, t2_1, t1_1, run_1};

  beat_timing_gen #(.PHASE_LEN(P0), .GAP_LEN(G0)) dut0 (
    .MF(MF), .CLR(CLR), .QD(qd[0]), .SHORT(short_s), .LONG(long_s), .STOP(stop_s),
`ifdef BEAT_SINGLE_STEP_EN
    .DP(dp),
`endif
    .W1(w1_0), .W2(w2_0), .W3(w3_0), .T1(t1_0), .T2(t2_0), .T3(t3_0), .RUN(run_0)
  );

  beat_timing_gen #(.PHASE_LEN(P1), .GAP_LEN(G1)) dut1 (
    .MF(MF), .CLR(CLR), .QD(qd[1]), .SHORT(short_s), .LONG(long_s), .STOP(stop_s),
`ifdef BEAT_SINGLE_STEP_EN
    .DP(dp),
`endif
    .W1(w1_1), .W2(w2_1), .W3(w3_1), .T1(t1_1), .T2(t2_1), .T3(t3_1), .RUN(run_1)
  );

  initial forever #5 MF = ~MF;

  int cyc = 0;
  always @(posedge MF) cyc <= cyc + 1;

  int   checks = 0;
  int   failures = 0;
  rec_t sb_q [$];
  logic [2:0] plan_q [$];   // per beat {stop, long, short} seen on the T3-dropping edge
  int   mbeat [2];          // pending beat per instance: 0 = W0, 1..3 = W1..W3
  bit   mon_en = 1'b0;

  function automatic int plen(input int d);
    return (d == 0) ? P0 : P1;
  endfunction

  function automatic int glen(input int d);
    return (d == 0) ? G0 : G1;
  endfunction

  function automatic logic [2:0] w_of(input int b);
    case (b)
      1:       return 3'b001;
      2:       return 3'b010;
      3:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int next_of(input int b, input logic s, input logic l);
    case (b)
      1:       return s ? 1 : 2;
      2:       return l ? 3 : 1;
      default: return 1;
    endcase
  endfunction

  function automatic logic [2:0] t_at(input int d, input int off);
    int p;
    p = plen(d);
    if (off < 0)     return 3'b000;
    if (off < p)     return 3'b001;
    if (off < 2 * p) return 3'b010;
    if (off < 3 * p) return 3'b100;
    return 3'b000;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] got,
                       input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", name, d, cyc, got, expv);
    end
  endtask

  // Monitor: pops a beat record whenever an instance raises T1, then checks every
  // cycle of that beat and the idle state that follows a halt.
  rec_t       cur [2];
  bit         active [2];
  logic [2:0] idle_w [2];
  logic       t1_prev [2];

  always @(negedge MF) begin : monitor
    int L;
    int off;
    logic [6:0] exp_val;
    for (int d = 0; d < 2; d++) begin
      L = 3 * plen(d) + glen(d);
      if (!mon_en) begin
        active[d] = 1'b0;
        idle_w[d] = 3'b000;
      end else begin
        if (obs[d][1] && !t1_prev[d]) begin
          if (sb_q.size() > 0 && sb_q[0].dut == d) begin
            cur[d] = sb_q.pop_front();
            active[d] = 1'b1;
            check("beat_start", d, 32'(cyc), 32'(cur[d].start));
            $display("beat dut%0d cyc=%0d W=%b halt=%0d", d, cyc, cur[d].w, cur[d].halt);
          end else begin
            check("t1_unexpected", d, 32'(obs[d][1]), 32'(0));
          end
        end
        if (active[d]) begin
          off = cyc - cur[d].start;
          if (off < L) begin
            exp_val = {cur[d].w, t_at(d, off), 1'b1};
            check("beat_outputs", d, 32'(obs[d]), 32'(exp_val));
          end else if (cur[d].halt) begin
            idle_w[d] = cur[d].next_w;
            active[d] = 1'b0;
            exp_val = {idle_w[d], 3'b000, 1'b0};
            check("halt_outputs", d, 32'(obs[d]), 32'(exp_val));
          end else begin
            check("beat_chain_t1", d, 32'(obs[d][1]), 32'(1));
            active[d] = 1'b0;
          end
        end else begin
          exp_val = {idle_w[d], 3'b000, 1'b0};
          check("idle_outputs", d, 32'(obs[d]), 32'(exp_val));
        end
      end
      t1_prev[d] = obs[d][1];
    end
  end

  task automatic add_plan(input logic [2:0] x);
    plan_q.push_back(x);
  endtask

  task automatic add_random_plan(input int n);
    for (int i = 0; i < n; i++)
      add_plan((i == n - 1) ? (3'b100 | 3'($urandom_range(0, 3))) : 3'($urandom_range(0, 3)));
  endtask

  // Press QD on instance d, push the predicted beats, and drive the controller
  // inputs (planned value on each sampling cycle, random elsewhere). A kill index
  // >= 0 pulls CLR in the middle of PH2 of that beat.
  task automatic run_dut(input int d, input int kill_idx);
    int p, g, L, n, s0, h, hold, b, nb, off;
    rec_t r;
    logic [2:0] kill_w;
    p = plen(d);
    g = glen(d);
    L = 3 * p + g;
    n = plan_q.size();
    kill_w = 3'b000;
    @(negedge MF);
    s0 = cyc + 4;
    h  = s0 + n * L;
    b  = mbeat[d];
    for (int k = 0; k < n; k++) begin
      nb = next_of(b, plan_q[k][0], plan_q[k][1]);
      r.dut = d;
      r.start = s0 + k * L;
      r.w = w_of(b);
      r.halt = plan_q[k][2];
      r.next_w = w_of(nb);
      if (k == kill_idx) kill_w = w_of(b);
      sb_q.push_back(r);
      b = nb;
    end
    mbeat[d] = b;
    qd[d] = 1'b1;
    hold = int'($urandom_range(1, 3 * L));
    while (cyc < h + 6) begin
      @(negedge MF);
      if (kill_idx >= 0 && cyc == s0 + kill_idx * L + p + 1) begin
        check("kill_in_ph2", d, 32'(obs[d]), 32'({kill_w, 3'b010, 1'b1}));
        mon_en = 1'b0;
        #2 CLR = 1'b0;
        #1;
        check("async_clear", 0, 32'(obs[0]), 32'(0));
        check("async_clear", 1, 32'(obs[1]), 32'(0));
        sb_q.delete();
        plan_q.delete();
        mbeat[0] = 0;
        mbeat[1] = 0;
        qd = 2'b00;
        @(negedge MF);
        @(negedge MF);
        CLR = 1'b1;
        @(negedge MF);
        mon_en = 1'b1;
        repeat (4) @(negedge MF);
        return;
      end
      if (cyc - s0 < hold)  qd[d] = 1'b1;
      else if (cyc + 4 <= h) qd[d] = 1'($urandom);
      else                   qd[d] = 1'b0;
      off = cyc - (s0 + 3 * p - 1);
      if (off >= 0 && off % L == 0 && off / L < n)
        {stop_s, long_s, short_s} = plan_q[off / L];
      else
        {stop_s, long_s, short_s} = 3'($urandom);
    end
    plan_q.delete();
    qd[d] = 1'b0;
    repeat (4) @(negedge MF);
  endtask

  initial begin : stimulus
    int b;
    int k;
    mbeat[0] = 0;
    mbeat[1] = 0;
    repeat (3) @(negedge MF);
    check("reset_outputs", 0, 32'(obs[0]), 32'(0));
    check("reset_outputs", 1, 32'(obs[1]), 32'(0));
    CLR = 1'b1;
    @(negedge MF);
    mon_en = 1'b1;
    repeat (3) @(negedge MF);

    // W0, W1, W2, W1, W2 with nothing asserted; stop on the last.
    repeat (4) add_plan(3'b000);
    add_plan(3'b100);
    run_dut(0, -1);
    // W1, W2 (LONG), W3, W1 (STOP) -> halts with W2 pending.
    add_plan(3'b000); add_plan(3'b010); add_plan(3'b000); add_plan(3'b100);
    run_dut(0, -1);
    // W2, W1 (SHORT), W1 (SHORT+LONG), W1 (STOP) -> halts holding W2.
    add_plan(3'b000); add_plan(3'b001); add_plan(3'b011); add_plan(3'b100);
    run_dut(0, -1);
    // Restart resumes at W2.
    add_plan(3'b100);
    run_dut(0, -1);

    for (int i = 0; i < 4; i++) begin
      add_random_plan(int'($urandom_range(1, 6)));
      run_dut(0, -1);
    end
    for (int i = 0; i < 3; i++) begin
      add_random_plan(int'($urandom_range(1, 5)));
      run_dut(1, -1);
    end

    // Walk instance 1 to a W3 beat and clear it in the middle of PH2.
    b = mbeat[1];
    k = 0;
    while (b != 3) begin
      add_plan((b == 2) ? 3'b010 : 3'b000);
      b = next_of(b, 1'b0, b == 2);
      k++;
    end
    add_plan(3'b100);
    run_dut(1, k);

    add_plan(3'b000); add_plan(3'b100);
    run_dut(1, -1);
    add_plan(3'b100);
    run_dut(0, -1);

    repeat (5) @(negedge MF);
    check("scoreboard_drained", 0, 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
